dds_sweep_ctrl: RTL and testbench

Frequency-sweep sequencer for the DDS core.
- Takes a sweep configuration (start/stop tuning word, step, dwell) from the UART command layer.
- Drives the DDS frequency tuning word point by point, holding each point for a programmable number of clocks.
- Supports single-shot and continuous sweeps, upward or downward, with abort.
- Sits between the command receiver and the phase accumulator's frequency input.

---
 rtl/dds_pkg.sv | 28 ++
 rtl/dds_step_calc.sv | 44 ++++
 rtl/dds_sweep_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dds_pkg                                                      |
// | Description : Shared widths, sweep state encoding and direction constants  |
// |               for the DDS frequency-sweep sequencer.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package dds_pkg;

    localparam int c_FREQ_W  = 24;
    localparam int c_DWELL_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DWELL   = 2'd1,
        ST_ADVANCE = 2'd2
    } sweep_state_t;

    localparam logic c_DIR_UP   = 1'b0;
    localparam logic c_DIR_DOWN = 1'b1;

    // A zero dwell means the point's only cycle is already the advance cycle.
    function automatic sweep_state_t hold_entry_state(input logic dwell_is_zero);
        return dwell_is_zero ? ST_ADVANCE : ST_DWELL;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dds_step_calc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dds_step_calc                                                |
// | Description : Combinational saturating next-point calculator; never steps  |
// |               past the stop word and never wraps.                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dds_step_calc
    import dds_pkg::*;
#(
    parameter int FREQ_W = c_FREQ_W
) (
    input  logic [FREQ_W-1:0] current,
    input  logic [FREQ_W-1:0] step,
    input  logic [FREQ_W-1:0] stop,
    input  logic              dir,
    output logic [FREQ_W-1:0] next,
    output logic              is_last
);

    logic [FREQ_W:0]   w_sum;
    logic [FREQ_W-1:0] w_gap;

    // One extra bit on the sum so a step near full scale cannot wrap past stop.
    assign w_sum = {1'b0, current} + {1'b0, step};
    assign w_gap = current - stop;

    always_comb begin
        next = stop;
        if (dir == c_DIR_UP) begin
            if (w_sum < {1'b0, stop}) begin
                next = w_sum[FREQ_W-1:0];
            end
        end else begin
            if (w_gap > step) begin
                next = current - step;
            end
        end
    end

    assign is_last = (current == stop) || (step == '0);

endmodule
`default_nettype wire

// File: rtl/dds_sweep_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dds_sweep_ctrl                                               |
// | Description : DDS frequency-sweep sequencer: steps the tuning word from    |
// |               start to stop, holding each point cfg_dwell+1 clocks.        |
// |               SWEEP_TRIANGLE_EN: continuous sweeps bounce between ends.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int FREQ_W  = c_FREQ_W,
    parameter int DWELL_W = c_DWELL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FREQ_W-1:0]  cfg_freq_start,
    input  logic [FREQ_W-1:0]  cfg_freq_stop,
    input  logic [FREQ_W-1:0]  cfg_freq_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_continuous,
    input  logic               start,
    input  logic               abort,
    output logic [FREQ_W-1:0]  freq_word,
    output logic               freq_update,
    output logic               busy,
    output logic               done
);

    sweep_state_t       r_state;
    sweep_state_t       w_state_nxt;
    sweep_state_t       w_hold_state;

    logic [FREQ_W-1:0]  r_freq;
    logic [FREQ_W-1:0]  w_freq_nxt;
    logic [FREQ_W-1:0]  r_start;
    logic [FREQ_W-1:0]  w_start_nxt;
    logic [FREQ_W-1:0]  r_stop;
    logic [FREQ_W-1:0]  w_stop_nxt;
    logic [FREQ_W-1:0]  r_step;
    logic [FREQ_W-1:0]  w_step_nxt;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] w_dwell_nxt;
    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W-1:0] w_cnt_nxt;
    logic [DWELL_W-1:0] w_cnt_inc;

    logic               r_dir;
    logic               w_dir_nxt;
    logic               r_cont;
    logic               w_cont_nxt;
    logic               r_upd;
    logic               w_upd_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               r_done;
    logic               w_done_nxt;

    logic               w_turn;
    logic [FREQ_W-1:0]  w_calc_stop;
    logic               w_calc_dir;
    logic [FREQ_W-1:0]  w_next;
    logic               w_is_last;

`ifdef SWEEP_TRIANGLE_EN
    // At an endpoint of a continuous sweep, aim at the opposite end and take
    // the first step back immediately so the endpoint is not emitted twice.
    assign w_turn = r_cont && (r_freq == r_stop) && (r_step != '0);
`else
    assign w_turn = 1'b0;
`endif

    assign w_calc_stop  = w_turn ? r_start : r_stop;
    assign w_calc_dir   = w_turn ? ~r_dir  : r_dir;
    assign w_cnt_inc    = r_cnt + 1'b1;
    assign w_hold_state = hold_entry_state(r_dwell == '0);

    dds_step_calc #(
        .FREQ_W (FREQ_W)
    ) u_step_calc (
        .current (r_freq),
        .step    (r_step),
        .stop    (w_calc_stop),
        .dir     (w_calc_dir),
        .next    (w_next),
        .is_last (w_is_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_freq  <= '0;
            r_start <= '0;
            r_stop  <= '0;
            r_step  <= '0;
            r_dwell <= '0;
            r_cnt   <= '0;
            r_dir   <= c_DIR_UP;
            r_cont  <= 1'b0;
            r_upd   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_freq  <= w_freq_nxt;
            r_start <= w_start_nxt;
            r_stop  <= w_stop_nxt;
            r_step  <= w_step_nxt;
            r_dwell <= w_dwell_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
            r_cont  <= w_cont_nxt;
            r_upd   <= w_upd_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_freq_nxt  = r_freq;
        w_start_nxt = r_start;
        w_stop_nxt  = r_stop;
        w_step_nxt  = r_step;
        w_dwell_nxt = r_dwell;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir;
        w_cont_nxt  = r_cont;
        w_upd_nxt   = 1'b0;
        w_done_nxt  = 1'b0;
        w_busy_nxt  = r_busy;

        if (abort) begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_start_nxt = cfg_freq_start;
                        w_stop_nxt  = cfg_freq_stop;
                        w_step_nxt  = cfg_freq_step;
                        w_dwell_nxt = cfg_dwell;
                        w_cont_nxt  = cfg_continuous;
                        w_dir_nxt   = (cfg_freq_stop >= cfg_freq_start) ? c_DIR_UP : c_DIR_DOWN;
                        w_freq_nxt  = cfg_freq_start;
                        w_upd_nxt   = 1'b1;
                        w_busy_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = hold_entry_state(cfg_dwell == '0);
                    end
                end

                // ADVANCE is the final cycle of each hold, so no clock is lost.
                ST_DWELL: begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == r_dwell) begin
                        w_state_nxt = ST_ADVANCE;
                    end
                end

                ST_ADVANCE: begin
                    w_cnt_nxt = '0;
                    if (w_turn) begin
                        w_freq_nxt  = w_next;
                        w_upd_nxt   = 1'b1;
                        w_start_nxt = r_stop;
                        w_stop_nxt  = r_start;
                        w_dir_nxt   = ~r_dir;
                        w_state_nxt = w_hold_state;
                    end else if (w_is_last) begin
                        if (r_cont) begin
                            w_freq_nxt  = r_start;
                            w_upd_nxt   = 1'b1;
                            w_state_nxt = w_hold_state;
                        end else begin
                            w_done_nxt  = 1'b1;
                            w_busy_nxt  = 1'b0;
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_freq_nxt  = w_next;
                        w_upd_nxt   = 1'b1;
                        w_state_nxt = w_hold_state;
                    end
                end

                default: begin
                    w_state_nxt = ST_IDLE;
                    w_busy_nxt  = 1'b0;
                end
            endcase
        end
    end

    assign freq_word   = r_freq;
    assign freq_update = r_upd;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_dds_sweep_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dds_sweep_ctrl                                            |
// | Description : Scoreboard bench for dds_sweep_ctrl with a point-list model. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_dds_sweep_ctrl;

    localparam int FW = 24;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] cfg_freq_start;
    logic [FW-1:0] cfg_freq_stop;
    logic [FW-1:0] cfg_freq_step;
    logic [DW-1:0] cfg_dwell;
    logic          cfg_continuous;
    logic          start;
    logic          abort;
    logic [FW-1:0] freq_word;
    logic          freq_update;
    logic          busy;
    logic          done;

    dds_sweep_ctrl #(.FREQ_W(FW), .DWELL_W(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_freq_start (cfg_freq_start),
        .cfg_freq_stop  (cfg_freq_stop),
        .cfg_freq_step  (cfg_freq_step),
        .cfg_dwell      (cfg_dwell),
        .cfg_continuous (cfg_continuous),
        .start          (start),
        .abort          (abort),
        .freq_word      (freq_word),
        .freq_update    (freq_update),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     cyc;
        longint val;
        bit     is_done;
    } ev_t;

    ev_t    exp_q[$];
    ev_t    mon_e;
    int     cyc = 0;
    int     vectors = 0;
    int     miscompares = 0;
    bit     mon_en = 1'b0;
    longint tb_last_freq = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every update or done pulse must match the head of the queue.
    always @(negedge clk) begin
        if (mon_en && !rst && (freq_update || done)) begin
            check("upd_done_overlap", longint'(freq_update & done), 0);
            if (exp_q.size() == 0) begin
                check("spurious_event", longint'({freq_update, done}), 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_kind", longint'(done), longint'(mon_e.is_done));
                check("event_cycle", longint'(cyc), longint'(mon_e.cyc));
                if (!mon_e.is_done) check("freq_word", longint'(freq_word), mon_e.val);
            end
        end
    end

    function automatic longint toward(input longint cur, input longint tgt, input longint st);
        if (tgt >= cur) return (cur + st > tgt) ? tgt : cur + st;
        return (cur - st < tgt) ? tgt : cur - st;
    endfunction

    // Reference: walk the point list toward the target, one point per dwell+1 clocks.
    task automatic model(input longint s, input longint p, input longint st, input int d,
                         input bit cont, input int c0, input int lim,
                         output int end_cyc, output longint last_val, output bit got_done);
        longint cur = s;
        longint tgt = p;
        longint org = s;
        longint tmp;
        int     t = c0 + 1;
        end_cyc  = lim;
        last_val = s;
        got_done = 1'b0;
        while (t <= lim) begin
            exp_q.push_back('{t, cur, 1'b0});
            last_val = cur;
            t += d + 1;
            if (cur == tgt || st == 0) begin
                if (!cont) begin
                    if (t <= lim) begin
                        exp_q.push_back('{t, cur, 1'b1});
                        end_cyc  = t;
                        got_done = 1'b1;
                    end
                    break;
                end
`ifdef SWEEP_TRIANGLE_EN
                if (st != 0) begin
                    tmp = org; org = tgt; tgt = tmp;
                    cur = toward(cur, tgt, st);
                end else begin
                    cur = org;
                end
`else
                tmp = tgt;
                cur = org;
`endif
            end else begin
                cur = toward(cur, tgt, st);
            end
        end
    endtask

    task automatic run_sweep(input longint s, input longint p, input longint st, input int d,
                             input bit cont, input int abort_off, input bit stray);
        int     c0;
        int     endc;
        int     a_cyc;
        longint lastv;
        bit     got_done;
        @(posedge clk); #1;
        cfg_freq_start = FW'(s);
        cfg_freq_stop  = FW'(p);
        cfg_freq_step  = FW'(st);
        cfg_dwell      = DW'(d);
        cfg_continuous = cont;
        start = 1'b1;
        abort = 1'b0;
        c0 = cyc;
        a_cyc = (abort_off > 0) ? c0 + abort_off : 32'h3fff_ffff;
        model(s, p, st, d, cont, c0, a_cyc, endc, lastv, got_done);
        while (cyc < endc + 1) begin
            @(posedge clk); #1;
            start = stray && (cyc < endc) && ($urandom_range(0, 3) == 0);
            abort = (cyc == a_cyc);
            cfg_freq_start = FW'($urandom);
            cfg_freq_stop  = FW'($urandom);
            cfg_freq_step  = FW'($urandom);
            cfg_dwell      = DW'($urandom);
            cfg_continuous = 1'($urandom);
            if (got_done && cyc == endc) begin
                @(negedge clk);
                check("busy_at_done", longint'(busy), 0);
            end
        end
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("busy_after_end", longint'(busy), 0);
        check("freq_hold", longint'(freq_word), lastv);
        tb_last_freq = lastv;
        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", longint'(exp_q.size()), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached with %0d events pending", exp_q.size());
        $fatal(1);
    end

    initial begin
        longint s, p, st, span;
        int     d;
        int     div;
        bit     cont;
        int     aoff;
        int     c0;

        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        cfg_freq_start = '0;
        cfg_freq_stop  = '0;
        cfg_freq_step  = '0;
        cfg_dwell      = '0;
        cfg_continuous = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_freq_word", longint'(freq_word), 0);
        check("rst_freq_update", longint'(freq_update), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        rst = 1'b0;
        mon_en = 1'b1;

        run_sweep(100, 130, 10, 2, 1'b0, 0, 1'b0);
        run_sweep(50, 20, 15, 0, 1'b0, 0, 1'b0);
        run_sweep(0, 25, 10, 1, 1'b0, 0, 1'b0);
        run_sweep(0, 24'hFFFFF0, 24'hFFFFFF, 1, 1'b0, 0, 1'b0);
        run_sweep(0, 20, 10, 0, 1'b1, 5, 1'b0);

        // start and abort together in IDLE: nothing may happen
        @(posedge clk); #1;
        cfg_freq_start = 24'd333;
        cfg_freq_stop  = 24'd444;
        cfg_freq_step  = 24'd11;
        cfg_dwell      = 16'd1;
        cfg_continuous = 1'b0;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("startabort_busy", longint'(busy), 0);
        check("startabort_freq", longint'(freq_word), tb_last_freq);
        repeat (4) @(posedge clk);

        run_sweep(7, 40, 0, 3, 1'b0, 0, 1'b0);
        run_sweep(7, 40, 0, 2, 1'b1, 10, 1'b0);
        run_sweep(0, 20, 10, 0, 1'b1, 12, 1'b0);
        run_sweep(0, 25, 10, 1, 1'b1, 30, 1'b1);
        run_sweep(90, 30, 20, 2, 1'b1, 40, 1'b1);

        // asynchronous reset in the middle of a dwell
        @(posedge clk); #1;
        cfg_freq_start = 24'd500;
        cfg_freq_stop  = 24'd900;
        cfg_freq_step  = 24'd100;
        cfg_dwell      = 16'd5;
        cfg_continuous = 1'b0;
        start = 1'b1;
        c0 = cyc;
        exp_q.push_back('{c0 + 1, 64'd500, 1'b0});
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_freq_word", longint'(freq_word), 0);
        check("arst_freq_update", longint'(freq_update), 0);
        check("arst_busy", longint'(busy), 0);
        check("arst_done", longint'(done), 0);
        check("arst_queue", longint'(exp_q.size()), 0);
        exp_q.delete();
        @(posedge clk); #1;
        check("arst_hold_busy", longint'(busy), 0);
        #2 rst = 1'b0;
        tb_last_freq = 0;
        repeat (3) @(posedge clk);

        for (int i = 0; i < 40; i++) begin
            s = longint'($urandom_range(0, 24'hFFFFFF));
            p = ($urandom_range(0, 7) == 0) ? s : longint'($urandom_range(0, 24'hFFFFFF));
            span = (p >= s) ? p - s : s - p;
            div = $urandom_range(1, 12);
            st = span / div + longint'($urandom_range(0, 3));
            if (st > 24'hFFFFFF) st = 24'hFFFFFF;
            if ($urandom_range(0, 9) == 0) st = 0;
            d = $urandom_range(0, 4);
            cont = ($urandom_range(0, 2) == 0);
            aoff = (cont || $urandom_range(0, 4) == 0) ? $urandom_range(1, 60) : 0;
            run_sweep(s, p, st, d, cont, aoff, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
